// File: rtl/sprite_layer_engine.sv
// Multi-sprite layer: shadow/active attribute tables swapped at vblank, 2-clock pixel lookup pipeline.
// Optional macro SPRITE_COLLISION_EN adds a sticky o_collision flag cleared at each table swap.
module sprite_layer_engine #(
  parameter logic [5:0]  DEVICE_ID    = 6'b001001,
  parameter int          NUM_SPRITES  = 4,
  parameter int          NUM_PATTERNS = 4,
  parameter int          PIX_BITS     = 2,
  parameter int          MEM_DEPTH    = 1024,
  parameter int          V_ACTIVE     = 480,
  parameter logic [23:0] BG_COLOR     = 24'h9290ff
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_write,
  input  logic [31:0] i_writedata,
  input  logic [9:0]  i_hcount,
  input  logic [9:0]  i_vcount,
  output logic [23:0] o_rgb_output,
  output logic        o_swap_pending
`ifdef SPRITE_COLLISION_EN
  ,
  output logic        o_collision
`endif
);

  localparam int SID_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  function automatic logic [23:0] f_palette(input logic [PIX_BITS-1:0] idx);
    logic [23:0] c;
    case (int'(idx))
      1:       c = 24'hff0000;
      2:       c = 24'h00ff00;
      3:       c = 24'h0000ff;
      default: c = {3{8'(idx)}};
    endcase
    return c;
  endfunction

  logic [5:0]       w_comp_id;
  logic [4:0]       w_sprite_id;
  logic [3:0]       w_cmd;
  logic [2:0]       w_type;
  logic [12:0]      w_data;
  logic [SID_W-1:0] w_sidx;
  logic             w_sel, w_attr, w_pixw, w_commit, w_swap;
  logic             w_unused;

  assign w_comp_id   = i_writedata[31:26];
  assign w_sprite_id = i_writedata[25:21];
  assign w_cmd       = i_writedata[20:17];
  assign w_type      = i_writedata[16:14];
  assign w_data      = i_writedata[12:0];
  assign w_sidx      = w_sprite_id[SID_W-1:0];
  assign w_unused    = ^{i_writedata[13], w_data[10]};

  assign w_sel    = i_write && (w_comp_id == DEVICE_ID) && (int'(w_sprite_id) < NUM_SPRITES);
  assign w_attr   = w_sel && (w_cmd == 4'h1);
  assign w_pixw   = w_sel && (w_cmd == 4'h2);
  assign w_commit = w_sel && (w_cmd == 4'hF);

  logic r_swap_pending;
  assign w_swap         = r_swap_pending && (i_vcount == 10'(V_ACTIVE)) && (i_hcount == 10'd0);
  assign o_swap_pending = r_swap_pending;

  logic [9:0]             r_sh_x   [NUM_SPRITES];
  logic [9:0]             r_sh_y   [NUM_SPRITES];
  logic [4:0]             r_sh_pat [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] r_sh_vis, r_sh_flip;
  logic [9:0]             r_ac_x   [NUM_SPRITES];
  logic [9:0]             r_ac_y   [NUM_SPRITES];
  logic [4:0]             r_ac_pat [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] r_ac_vis, r_ac_flip;

  // A commit in the swap cycle keeps the flag set so it lands on the following vblank.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        r_sh_x[s]   <= '0;
        r_sh_y[s]   <= '0;
        r_sh_pat[s] <= '0;
        r_ac_x[s]   <= '0;
        r_ac_y[s]   <= '0;
        r_ac_pat[s] <= '0;
      end
      r_sh_vis       <= '0;
      r_sh_flip      <= '0;
      r_ac_vis       <= '0;
      r_ac_flip      <= '0;
      r_swap_pending <= 1'b0;
    end else begin
      if (w_swap) begin
        r_ac_x    <= r_sh_x;
        r_ac_y    <= r_sh_y;
        r_ac_pat  <= r_sh_pat;
        r_ac_vis  <= r_sh_vis;
        r_ac_flip <= r_sh_flip;
      end
      if (w_attr) begin
        case (w_type)
          3'b000: r_sh_x[w_sidx] <= w_data[9:0];
          3'b001: r_sh_y[w_sidx] <= w_data[9:0];
          3'b010: if (int'(w_data[4:0]) < NUM_PATTERNS) r_sh_pat[w_sidx] <= w_data[4:0];
          3'b011: begin
            r_sh_vis[w_sidx]  <= w_data[12];
            r_sh_flip[w_sidx] <= w_data[11];
          end
          default: ;
        endcase
      end
      if (w_commit)    r_swap_pending <= 1'b1;
      else if (w_swap) r_swap_pending <= 1'b0;
    end
  end

  logic [9:0]          r_ld_addr;
  logic [PIX_BITS-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ld_addr <= '0;
    end else if (w_pixw && (w_type == 3'b111)) begin
      r_ld_addr <= w_data[9:0];
    end else if (w_pixw && (w_type == 3'b110)) begin
      r_ld_addr <= (int'(r_ld_addr) >= MEM_DEPTH - 1) ? 10'd0 : r_ld_addr + 10'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_pixw && (w_type == 3'b110) && (int'(r_ld_addr) < MEM_DEPTH))
      r_mem[r_ld_addr[MEM_AW-1:0]] <= w_data[12 -: PIX_BITS];
  end

  // 11-bit subtract: bit 10 flags a borrow, so positions left of the sprite never alias into it.
  logic [10:0]            w_dx   [NUM_SPRITES];
  logic [10:0]            w_dy   [NUM_SPRITES];
  logic [3:0]             w_col  [NUM_SPRITES];
  logic [12:0]            w_addr [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] w_hit;

  always_comb begin
    w_hit = '0;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      w_dx[s]   = {1'b0, i_hcount} - {1'b0, r_ac_x[s]};
      w_dy[s]   = {1'b0, i_vcount} - {1'b0, r_ac_y[s]};
      w_col[s]  = r_ac_flip[s] ? ~w_dx[s][3:0] : w_dx[s][3:0];
      w_addr[s] = {r_ac_pat[s], w_dy[s][3:0], w_col[s]};
      w_hit[s]  = r_ac_vis[s] && (w_dx[s][10:4] == '0) && (w_dy[s][10:4] == '0)
                  && (int'(w_addr[s]) < MEM_DEPTH);
    end
  end

  logic [NUM_SPRITES-1:0] r_s1_hit;
  logic [MEM_AW-1:0]      r_s1_addr [NUM_SPRITES];
  logic [PIX_BITS-1:0]    r_s2_pix  [NUM_SPRITES];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_s1_hit <= '0;
      for (int s = 0; s < NUM_SPRITES; s++) begin
        r_s1_addr[s] <= '0;
        r_s2_pix[s]  <= '0;
      end
    end else begin
      r_s1_hit <= w_hit;
      for (int s = 0; s < NUM_SPRITES; s++) begin
        r_s1_addr[s] <= w_addr[s][MEM_AW-1:0];
        r_s2_pix[s]  <= r_s1_hit[s] ? r_mem[r_s1_addr[s]] : '0;
      end
    end
  end

  logic w_found;

  always_comb begin
    o_rgb_output = BG_COLOR;
    w_found      = 1'b0;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      if (!w_found && (r_s2_pix[s] != '0)) begin
        o_rgb_output = f_palette(r_s2_pix[s]);
        w_found      = 1'b1;
      end
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic w_any, w_multi, r_coll;

  always_comb begin
    w_any   = 1'b0;
    w_multi = 1'b0;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      if (r_s2_pix[s] != '0) begin
        if (w_any) w_multi = 1'b1;
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)     r_coll <= 1'b0;
    else if (w_swap)  r_coll <= 1'b0;
    else if (w_multi) r_coll <= 1'b1;
  end

  assign o_collision = r_coll;
`endif

endmodule

// File: tb/tb_sprite_layer_engine.sv
// Self-checking bench for sprite_layer_engine: reference model of the tables and pixel memory,
// expected pixels queued per presented coordinate and compared two clocks later.
module tb_sprite_layer_engine;

  localparam logic [5:0]  DEV = 6'b001001;
  localparam logic [23:0] BG  = 24'h9290ff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write;
  logic [31:0] writedata;
  logic [9:0]  hcount, vcount;
  logic [23:0] rgb;
  logic        swap_pending;
`ifdef SPRITE_COLLISION_EN
  logic        collision;
  bit          exp_coll;
`endif

  always #5 clk = ~clk;

  sprite_layer_engine dut (
    .i_clk(clk), .i_reset(rst_n), .i_write(write), .i_writedata(writedata),
    .i_hcount(hcount), .i_vcount(vcount), .o_rgb_output(rgb), .o_swap_pending(swap_pending)
`ifdef SPRITE_COLLISION_EN
    , .o_collision(collision)
`endif
  );

  typedef struct {int x; int y; int pat; int vis; int flip;} attr_t;
  typedef struct {bit chk; logic [23:0] rgb; int h; int v;} exp_t;

  attr_t sh[4];
  attr_t ac[4];
  int    mem[1024];
  bit    m_pend;
  exp_t  q[$];
  int    checks = 0;
  int    passed = 0;

  function automatic logic [23:0] pal(input int p);
    if (p == 1) return 24'hff0000;
    if (p == 2) return 24'h00ff00;
    return 24'h0000ff;
  endfunction

  function automatic int pix_at(input int s, input int h, input int v);
    int dx, dy, col, a;
    if (ac[s].vis == 0) return 0;
    dx = h - ac[s].x;
    dy = v - ac[s].y;
    if (dx < 0 || dx > 15 || dy < 0 || dy > 15) return 0;
    col = (ac[s].flip != 0) ? 15 - dx : dx;
    a = ac[s].pat * 256 + dy * 16 + col;
    if (a >= 1024) return 0;
    return mem[a];
  endfunction

  function automatic logic [23:0] exp_rgb(input int h, input int v);
    int p;
    for (int s = 0; s < 4; s++) begin
      p = pix_at(s, h, v);
      if (p != 0) return pal(p);
    end
    return BG;
  endfunction

  function automatic int opaque_cnt(input int h, input int v);
    int n;
    n = 0;
    for (int s = 0; s < 4; s++) if (pix_at(s, h, v) != 0) n++;
    return n;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 4; s++) begin
      sh[s] = '{0, 0, 0, 0, 0};
      ac[s] = '{0, 0, 0, 0, 0};
    end
    m_pend = 1'b0;
`ifdef SPRITE_COLLISION_EN
    exp_coll = 1'b0;
`endif
  endfunction

  function automatic void model_attr(input int s, input int typ, input int d);
    case (typ)
      0: sh[s].x = d & 1023;
      1: sh[s].y = d & 1023;
      2: if (d < 4) sh[s].pat = d;
      3: begin sh[s].vis = (d >> 12) & 1; sh[s].flip = (d >> 11) & 1; end
      default: ;
    endcase
  endfunction

  task automatic wr(input logic [5:0] cid, input logic [4:0] sid, input logic [3:0] cmd,
                    input logic [2:0] typ, input logic [12:0] data);
    write = 1'b1;
    writedata = {cid, sid, cmd, typ, 1'b0, data};
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic attr(input int s, input int typ, input int d);
    wr(DEV, 5'(s), 4'h1, 3'(typ), 13'(d));
    model_attr(s, typ, d);
  endtask

  task automatic commit();
    wr(DEV, 5'd0, 4'hF, 3'd0, 13'd0);
    m_pend = 1'b1;
  endtask

  task automatic do_swap(input bit with_commit, input bit with_attr, input int s, input int typ, input int d);
    vcount = 10'd480;
    hcount = 10'd0;
    if (with_commit) begin
      write = 1'b1; writedata = {DEV, 5'd0, 4'hF, 3'd0, 1'b0, 13'd0};
    end else if (with_attr) begin
      write = 1'b1; writedata = {DEV, 5'(s), 4'h1, 3'(typ), 1'b0, 13'(d)};
    end
    @(posedge clk); #1;
    write = 1'b0; vcount = 10'd1023; hcount = 10'd1023;
    if (m_pend) begin
      ac = sh;
`ifdef SPRITE_COLLISION_EN
      exp_coll = 1'b0;
`endif
    end
    m_pend = with_commit;
    if (with_attr) model_attr(s, typ, d);
  endtask

  task automatic scan(input int v, input int h0, input int h1, input string name);
    exp_t e;
    for (int h = h0; h <= h1 + 2; h++) begin
      if (h <= h1) begin
        hcount = 10'(h); vcount = 10'(v);
        e.chk = 1'b1; e.rgb = exp_rgb(h, v); e.h = h; e.v = v;
`ifdef SPRITE_COLLISION_EN
        if (opaque_cnt(h, v) >= 2) exp_coll = 1'b1;
`endif
      end else begin
        hcount = 10'd1023; vcount = 10'd1023;
        e.chk = 1'b0; e.rgb = BG; e.h = 0; e.v = 0;
      end
      q.push_back(e);
      @(negedge clk);
      if (q.size() == 3) begin
        e = q.pop_front();
        if (e.chk) begin
          checks++;
          if (rgb !== e.rgb)
            $display("FAIL %s pixel(%0d,%0d) rgb got %h want %h", name, e.h, e.v, rgb, e.rgb);
          else passed++;
        end
      end
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  task automatic load_memory();
    int j, col, val;
    wr(DEV, 5'd0, 4'h2, 3'b111, 13'd0);
    for (int i = 0; i < 1024; i++) begin
      j = i % 256; col = j % 16;
      case (i / 256)
        0: val = (j % 3) + 1;
        1: val = j % 2;
        2: val = (col == 0) ? 1 : ((col == 15) ? 2 : 0);
        default: val = 3;
      endcase
      mem[i] = val;
      wr(DEV, 5'd0, 4'h2, 3'b110, 13'(val << 11));
    end
    // latch has wrapped back to 0
    wr(DEV, 5'd0, 4'h2, 3'b110, 13'(2 << 11));
    mem[0] = 2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; write = 1'b0; writedata = '0; hcount = '0; vcount = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rgb !== BG) $display("FAIL reset_rgb got %h want %h", rgb, BG); else passed++;
    checks++; if (swap_pending !== 1'b0) $display("FAIL reset_pending got %b want 0", swap_pending); else passed++;
    rst_n = 1'b1; hcount = 10'd1023; vcount = 10'd1023;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    attr(0, 0, 100); attr(0, 1, 50); attr(0, 2, 0); attr(0, 3, 13'h1000);
    commit();
    checks++; if (swap_pending !== 1'b1) $display("FAIL commit_pending got %b want 1", swap_pending); else passed++;
    scan(50, 98, 104, "pre_swap");
    do_swap(1'b0, 1'b0, 0, 0, 0);
    checks++; if (swap_pending !== 1'b0) $display("FAIL swap_clears_pending got %b want 0", swap_pending); else passed++;
    scan(50, 96, 118, "row50");
    scan(65, 99, 102, "row65");
    scan(66, 100, 102, "row66");
    scan(49, 100, 101, "row49");
  endtask

  task automatic test_shadow();
    attr(0, 0, 300);
    scan(50, 98, 102, "no_commit");
    do_swap(1'b0, 1'b0, 0, 0, 0);
    scan(50, 98, 102, "no_commit_vblank");
    commit();
    do_swap(1'b1, 1'b0, 0, 0, 0);
    checks++; if (swap_pending !== 1'b1) $display("FAIL commit_in_swap_pending got %b want 1", swap_pending); else passed++;
    scan(50, 299, 302, "swap_x300");
    do_swap(1'b0, 1'b1, 0, 0, 400);
    checks++; if (swap_pending !== 1'b0) $display("FAIL deferred_swap_pending got %b want 0", swap_pending); else passed++;
    scan(50, 298, 302, "attr_in_swap_old");
    scan(50, 399, 401, "attr_in_swap_new");
    commit();
    do_swap(1'b0, 1'b0, 0, 0, 0);
    scan(50, 399, 402, "x400");
  endtask

  task automatic test_priority();
    attr(0, 0, 200); attr(0, 1, 200); attr(0, 2, 0);
    attr(1, 0, 200); attr(1, 1, 200); attr(1, 2, 3); attr(1, 3, 13'h1000);
    commit();
    do_swap(1'b0, 1'b0, 0, 0, 0);
    scan(200, 198, 217, "ovl_opaque");
`ifdef SPRITE_COLLISION_EN
    checks++; if (collision !== exp_coll) $display("FAIL collision_set got %b want %b", collision, exp_coll); else passed++;
    scan(230, 198, 202, "no_ovl");
    checks++; if (collision !== 1'b1) $display("FAIL collision_sticky got %b want 1", collision); else passed++;
`endif
    attr(0, 2, 1);
    commit();
    do_swap(1'b0, 1'b0, 0, 0, 0);
`ifdef SPRITE_COLLISION_EN
    checks++; if (collision !== 1'b0) $display("FAIL collision_swap_clear got %b want 0", collision); else passed++;
`endif
    scan(201, 198, 217, "ovl_transp");
`ifdef SPRITE_COLLISION_EN
    checks++; if (collision !== exp_coll) $display("FAIL collision_reset got %b want %b", collision, exp_coll); else passed++;
`endif
  endtask

  task automatic test_flip_edge();
    attr(2, 0, 500); attr(2, 1, 100); attr(2, 2, 2); attr(2, 3, 13'h1800);
    attr(3, 0, 1015); attr(3, 1, 300); attr(3, 2, 0); attr(3, 3, 13'h1000);
    commit();
    do_swap(1'b0, 1'b0, 0, 0, 0);
    scan(100, 498, 517, "flip");
    scan(300, 1010, 1023, "x1015_right");
    scan(300, 0, 8, "x1015_wrap");
  endtask

  task automatic test_ignored();
    wr(6'h3F, 5'd0, 4'hF, 3'd0, 13'd0);
    checks++; if (swap_pending !== 1'b0) $display("FAIL foreign_commit got %b want 0", swap_pending); else passed++;
    wr(6'h00, 5'd0, 4'h1, 3'd0, 13'd700);
    wr(DEV, 5'd5, 4'h1, 3'd0, 13'd600);
    wr(DEV, 5'd4, 4'h1, 3'd3, 13'h0000);
    wr(DEV, 5'd0, 4'h1, 3'd2, 13'd4);
    wr(DEV, 5'd1, 4'h5, 3'd0, 13'd800);
    writedata = {DEV, 5'd0, 4'h1, 3'd0, 1'b0, 13'd800};
    @(posedge clk); #1;
    commit();
    do_swap(1'b0, 1'b0, 0, 0, 0);
    scan(205, 198, 217, "ignored_writes");
  endtask

  task automatic test_reset_mid();
    logic [23:0] want;
    commit();
    hcount = 10'd205; vcount = 10'd205;
    want = exp_rgb(205, 205);
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (rgb !== want) $display("FAIL pre_reset_rgb got %h want %h", rgb, want); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rgb !== BG) $display("FAIL midreset_rgb got %h want %h", rgb, BG); else passed++;
    checks++; if (swap_pending !== 1'b0) $display("FAIL midreset_pending got %b want 0", swap_pending); else passed++;
`ifdef SPRITE_COLLISION_EN
    checks++; if (collision !== 1'b0) $display("FAIL midreset_collision got %b want 0", collision); else passed++;
`endif
    model_reset();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    hcount = 10'd1023; vcount = 10'd1023;
    scan(205, 200, 206, "post_reset");
    commit();
    do_swap(1'b0, 1'b0, 0, 0, 0);
    scan(200, 198, 217, "post_reset_swap");
    scan(100, 498, 502, "post_reset_flip");
  endtask

  initial begin
    test_reset();
    load_memory();
    test_basic();
    test_shadow();
    test_priority();
    test_flip_edge();
    test_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
